// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator dispatch controller:
// FSM states, response status codes and accelerator selectors.
package accel_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_WAIT,
      ST_STORE,
      ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      STAT_OK      = 2'b00,
      STAT_ACC_ERR = 2'b01,
      STAT_TIMEOUT = 2'b10,
      STAT_ILL_SEL = 2'b11
   } status_t;

   typedef enum logic [1:0] {
      SEL_CRYPTO  = 2'd0,
      SEL_DSP     = 2'd1,
      SEL_AI      = 2'd2,
      SEL_ILLEGAL = 2'd3
   } sel_t;

   // Bytes per operand block (data, parameters and result are all 16 bytes).
   localparam int NBYTES = 16;

endpackage

// File: rtl/accel_dispatch_controller.sv
// Accepts a command, gathers data/parameter bytes from memory, runs one accelerator
// operation, optionally writes the result back (or keeps it for a fused follow-up), then responds.
module accel_dispatch_controller
   import accel_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_sel,
   input  logic [7:0]        cmd_op,
   input  logic              cmd_fuse,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_prm,
   input  logic [ADDR_W-1:0] cmd_dst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic [1:0]        acc_sel,
   output logic [7:0]        acc_op,
   output logic              acc_enable,
   output logic              acc_fusion,
   output logic [127:0]      acc_data,
   output logic [127:0]      acc_param,
   input  logic [127:0]      acc_result,
   input  logic              acc_done,
   input  logic              acc_error,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [1:0]        resp_status
);

   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam logic [TCW-1:0] TIMEOUT_V = TCW'(TIMEOUT);
   localparam logic [4:0] LAST_SLOT = 5'(2 * NBYTES - 1);

   state_t            state, state_nxt;
   sel_t              sel_q;
   logic [7:0]        op_q;
   logic              fuse_q;
   logic [ADDR_W-1:0] src_q, prm_q, dst_q;
   logic [127:0]      data_buf, prm_buf, res_buf;
   logic              res_vld;
   status_t           status_q;
   logic [5:0]        idx;
   logic [TCW-1:0]    tcnt;
   logic [TCW-1:0]    tcnt_inc;
   logic              timed_out;
   logic              issuing;
   logic              last_cap;
   logic              accept;
   logic              skip_data;

   // Read slot being returned this cycle: 0..15 data bytes, 16..31 parameter bytes.
   logic              rd_vld_p1;
   logic [4:0]        rd_slot_p1;

   assign accept    = (state == ST_IDLE) && cmd_valid;
   assign skip_data = cmd_fuse && res_vld;
   assign issuing   = (state == ST_LOAD) && !idx[5];
   assign last_cap  = rd_vld_p1 && (rd_slot_p1 == LAST_SLOT);
   assign tcnt_inc  = tcnt + 1'b1;
   assign timed_out = (tcnt_inc == TIMEOUT_V);

   assign acc_sel    = sel_q;
   assign acc_op     = op_q;
   assign acc_fusion = fuse_q;
   assign acc_data   = data_buf;
   assign acc_param  = prm_buf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      cmd_ready   = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      acc_enable  = 1'b0;
      resp_valid  = 1'b0;
      resp_status = 2'b00;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = (cmd_sel == SEL_ILLEGAL) ? ST_RESP : ST_LOAD;
         end
         ST_LOAD: begin
            if (issuing) begin
               mem_req  = 1'b1;
               mem_addr = idx[4] ? (prm_q + ADDR_W'(idx[3:0])) : (src_q + ADDR_W'(idx[3:0]));
            end
            if (last_cap) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            acc_enable = 1'b1;
            state_nxt  = ST_WAIT;
         end
         ST_WAIT: begin
            acc_enable = 1'b1;
            // Error outranks done, and a done in the final window cycle outranks the timeout.
            if (acc_error)      state_nxt = ST_RESP;
            else if (acc_done)  state_nxt = fuse_q ? ST_RESP : ST_STORE;
            else if (timed_out) state_nxt = ST_RESP;
         end
         ST_STORE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = dst_q + ADDR_W'(idx[3:0]);
            mem_wdata = res_buf[{idx[3:0], 3'b000} +: 8];
            if (idx[3:0] == 4'hF) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid  = 1'b1;
            resp_status = status_q;
            if (resp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q      <= SEL_CRYPTO;
         op_q       <= '0;
         fuse_q     <= 1'b0;
         src_q      <= '0;
         prm_q      <= '0;
         dst_q      <= '0;
         data_buf   <= '0;
         prm_buf    <= '0;
         res_buf    <= '0;
         res_vld    <= 1'b0;
         status_q   <= STAT_OK;
         idx        <= '0;
         tcnt       <= '0;
         rd_vld_p1  <= 1'b0;
         rd_slot_p1 <= '0;
      end else begin
         // ---- read-return stage: address issued last cycle, byte arrives now ----
         rd_vld_p1  <= issuing;
         rd_slot_p1 <= idx[4:0];
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  sel_q    <= sel_t'(cmd_sel);
                  op_q     <= cmd_op;
                  fuse_q   <= cmd_fuse;
                  src_q    <= cmd_src;
                  prm_q    <= cmd_prm;
                  dst_q    <= cmd_dst;
                  idx      <= skip_data ? 6'd16 : 6'd0;
                  status_q <= (cmd_sel == SEL_ILLEGAL) ? STAT_ILL_SEL : STAT_OK;
                  if (skip_data) data_buf <= res_buf;
                  if (cmd_sel == SEL_ILLEGAL) res_vld <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (issuing) idx <= idx + 1'b1;
               if (rd_vld_p1) begin
                  if (rd_slot_p1[4]) prm_buf[{rd_slot_p1[3:0], 3'b000} +: 8]  <= mem_rdata;
                  else               data_buf[{rd_slot_p1[3:0], 3'b000} +: 8] <= mem_rdata;
               end
            end
            ST_ISSUE: tcnt <= '0;
            ST_WAIT: begin
               tcnt <= tcnt_inc;
               if (acc_error) begin
                  status_q <= STAT_ACC_ERR;
                  res_vld  <= 1'b0;
               end else if (acc_done) begin
                  // Any successful result is chainable by the next fused command.
                  res_buf  <= acc_result;
                  res_vld  <= 1'b1;
                  status_q <= STAT_OK;
                  idx      <= '0;
               end else if (timed_out) begin
                  status_q <= STAT_TIMEOUT;
                  res_vld  <= 1'b0;
               end
            end
            ST_STORE: idx <= idx + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_accel_dispatch_controller.sv
// Randomized scoreboard bench for accel_dispatch_controller with memory and accelerator responders.
module tb_accel_dispatch_controller;

   localparam int TIMEOUT = 8;
   localparam int ADDR_W  = 8;

   logic          clk = 0;
   logic          rst = 1;
   logic          cmd_valid = 0;
   logic          cmd_ready;
   logic [1:0]    cmd_sel = 0;
   logic [7:0]    cmd_op = 0;
   logic          cmd_fuse = 0;
   logic [7:0]    cmd_src = 0, cmd_prm = 0, cmd_dst = 0;
   logic          mem_req, mem_we;
   logic [7:0]    mem_addr, mem_wdata;
   logic [7:0]    mem_rdata;
   logic [1:0]    acc_sel;
   logic [7:0]    acc_op;
   logic          acc_enable, acc_fusion;
   logic [127:0]  acc_data, acc_param;
   logic [127:0]  acc_result = 0;
   logic          acc_done, acc_error;
   logic          resp_valid;
   logic          resp_ready = 0;
   logic [1:0]    resp_status;

   accel_dispatch_controller #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_op(cmd_op),
      .cmd_fuse(cmd_fuse), .cmd_src(cmd_src), .cmd_prm(cmd_prm), .cmd_dst(cmd_dst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .acc_sel(acc_sel), .acc_op(acc_op), .acc_enable(acc_enable), .acc_fusion(acc_fusion),
      .acc_data(acc_data), .acc_param(acc_param), .acc_result(acc_result),
      .acc_done(acc_done), .acc_error(acc_error),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   sel;
      logic [7:0]   op;
      logic         fus;
      logic [127:0] data;
      logic [127:0] param;
      int           len;
   } acc_exp_t;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [7:0]   mem [256];
   logic [7:0]   ref_mem [256];
   logic [7:0]   exp_reads [$];
   logic [15:0]  exp_writes [$];
   acc_exp_t     exp_acc [$];
   logic [1:0]   exp_resp [$];
   logic [127:0] m_res = 0;
   logic         m_res_vld = 0;
   int           plan_kind = 0;
   int           plan_dly = 1;
   int           en_cnt;
   int           resp_seen = 0;
   int           wr_seen = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   // Accelerator responder: kind 0 done, 1 error, 2 both, 3 silent; fires plan_dly cycles after enable rises.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         en_cnt    <= 0;
         acc_done  <= 1'b0;
         acc_error <= 1'b0;
      end else begin
         en_cnt    <= acc_enable ? en_cnt + 1 : 0;
         acc_done  <= acc_enable && (en_cnt + 1 == plan_dly) && (plan_kind == 0 || plan_kind == 2);
         acc_error <= acc_enable && (en_cnt + 1 == plan_dly) && (plan_kind == 1 || plan_kind == 2);
      end
   end

   acc_exp_t   cur;
   logic       en_prev = 0;
   int         en_len = 0;
   logic [15:0] wexp;

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we && !mem_req) chk("we_without_req", 128'(1), 128'(0));
         if (mem_req && !mem_we) begin
            chk("read_expected", 128'(exp_reads.size() != 0), 128'(1));
            if (exp_reads.size() != 0) chk("read_addr", 128'(mem_addr), 128'(exp_reads.pop_front()));
         end
         if (mem_req && mem_we) begin
            chk("write_expected", 128'(exp_writes.size() != 0), 128'(1));
            if (exp_writes.size() != 0) begin
               wexp = exp_writes.pop_front();
               chk("write_addr", 128'(mem_addr), 128'(wexp[15:8]));
               chk("write_data", 128'(mem_wdata), 128'(wexp[7:0]));
               ref_mem[wexp[15:8]] = wexp[7:0];
            end
            wr_seen++;
         end
         if (acc_enable && !en_prev) begin
            chk("acc_expected", 128'(exp_acc.size() != 0), 128'(1));
            if (exp_acc.size() != 0) cur = exp_acc.pop_front();
            chk("acc_sel", 128'(acc_sel), 128'(cur.sel));
            chk("acc_op", 128'(acc_op), 128'(cur.op));
            chk("acc_fusion", 128'(acc_fusion), 128'(cur.fus));
            chk("acc_data", acc_data, cur.data);
            chk("acc_param", acc_param, cur.param);
            en_len = 1;
         end else if (acc_enable) begin
            en_len++;
            chk("acc_data_stable", acc_data, cur.data);
            chk("acc_param_stable", acc_param, cur.param);
         end else if (en_prev) begin
            chk("acc_enable_len", 128'(en_len), 128'(cur.len));
         end
         en_prev = acc_enable;
         if (resp_valid && resp_ready) begin
            chk("resp_expected", 128'(exp_resp.size() != 0), 128'(1));
            if (exp_resp.size() != 0) chk("resp_status", 128'(resp_status), 128'(exp_resp.pop_front()));
            resp_seen++;
         end
      end else begin
         en_prev = 1'b0;
      end
   end

   task automatic flush_exp();
      exp_reads.delete();
      exp_writes.delete();
      exp_acc.delete();
      exp_resp.delete();
   endtask

   task automatic run_cmd(input logic [1:0] sel, input logic [7:0] op, input logic fuse,
                          input logic [7:0] src, input logic [7:0] prm, input logic [7:0] dst,
                          input int kind, input int dly, input int abort_wr);
      logic [127:0] dat, pb, res;
      logic [1:0]   st;
      logic [7:0]   a;
      acc_exp_t     ae;
      int           guard, r0, w0;
      dat = '0;
      pb  = '0;
      res = {$urandom, $urandom, $urandom, $urandom};
      if (sel == 2'd3)                                  st = 2'd3;
      else if (kind == 3 || dly < 1 || dly > TIMEOUT)   st = 2'd2;
      else if (kind == 0)                               st = 2'd0;
      else                                              st = 2'd1;
      if (sel != 2'd3) begin
         if (fuse && m_res_vld) dat = m_res;
         else for (int k = 0; k < 16; k++) begin
            a = src + 8'(k);
            exp_reads.push_back(a);
            dat[8*k +: 8] = ref_mem[a];
         end
         for (int k = 0; k < 16; k++) begin
            a = prm + 8'(k);
            exp_reads.push_back(a);
            pb[8*k +: 8] = ref_mem[a];
         end
         ae.sel = sel; ae.op = op; ae.fus = fuse; ae.data = dat; ae.param = pb;
         ae.len = (st == 2'd2) ? TIMEOUT + 1 : dly + 1;
         exp_acc.push_back(ae);
         if (st == 2'd0) begin
            m_res = res;
            m_res_vld = 1'b1;
            if (!fuse) for (int k = 0; k < 16; k++) exp_writes.push_back({dst + 8'(k), res[8*k +: 8]});
         end else m_res_vld = 1'b0;
      end else m_res_vld = 1'b0;
      exp_resp.push_back(st);
      plan_kind = kind; plan_dly = dly; acc_result = res;

      cmd_sel = sel; cmd_op = op; cmd_fuse = fuse; cmd_src = src; cmd_prm = prm; cmd_dst = dst;
      cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      chk("cmd_accept", 128'(cmd_ready), 128'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("resp_next_cycle", 128'(resp_valid), 128'(sel == 2'd3));
      r0 = resp_seen; w0 = wr_seen; guard = 0;
      while (resp_seen == r0 && guard < 400) begin
         if (abort_wr >= 0 && wr_seen - w0 >= abort_wr) break;
         resp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1; guard++;
      end
      resp_ready = 1'b0;
      if (abort_wr >= 0) begin
         rst = 1'b1;
         #1;
         chk("rst_mem_req", 128'(mem_req), 128'(0));
         chk("rst_mem_we", 128'(mem_we), 128'(0));
         chk("rst_resp_valid", 128'(resp_valid), 128'(0));
         flush_exp();
         m_res_vld = 1'b0;
         repeat (2) @(posedge clk);
         #1; rst = 1'b0;
         @(posedge clk); #1;
         chk("post_rst_cmd_ready", 128'(cmd_ready), 128'(1));
         chk("post_rst_acc_data", acc_data, 128'(0));
         chk("writes_before_abort", 128'(wr_seen - w0), 128'(abort_wr));
      end else begin
         chk("cmd_complete", 128'(resp_seen != r0), 128'(1));
         if (resp_seen == r0) flush_exp();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] s;
      int         r, kd;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
      chk("rst_mem_req0", 128'(mem_req), 128'(0));
      chk("rst_acc_enable", 128'(acc_enable), 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("init_cmd_ready", 128'(cmd_ready), 128'(1));
      chk("init_resp_valid", 128'(resp_valid), 128'(0));
      chk("init_acc_data", acc_data, 128'(0));
      chk("init_outputs", 128'({acc_sel, acc_op, acc_fusion, mem_req, mem_we, resp_status}), 128'(0));

      run_cmd(2'd1, 8'h21, 1'b0, 8'h10, 8'h40, 8'h80, 0, 3, -1);
      run_cmd(2'd2, 8'h33, 1'b1, 8'h00, 8'h60, 8'hA0, 0, 2, -1);
      run_cmd(2'd0, 8'h05, 1'b0, 8'h20, 8'h30, 8'h90, 2, 4, -1);
      run_cmd(2'd1, 8'h06, 1'b1, 8'h50, 8'h70, 8'hB0, 0, 1, -1);
      run_cmd(2'd2, 8'h07, 1'b0, 8'h01, 8'h02, 8'h03, 3, 0, -1);
      run_cmd(2'd3, 8'h09, 1'b1, 8'h11, 8'h22, 8'h33, 0, 2, -1);
      run_cmd(2'd1, 8'h08, 1'b0, 8'hF8, 8'hFC, 8'hF5, 0, TIMEOUT, -1);
      run_cmd(2'd0, 8'h0A, 1'b0, 8'h44, 8'h55, 8'h66, 0, TIMEOUT + 1, -1);

      for (int n = 0; n < 40; n++) begin
         r  = $urandom_range(0, 9);
         s  = (r == 0) ? 2'd3 : 2'(r % 3);
         r  = $urandom_range(0, 9);
         kd = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
         run_cmd(s, 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 kd, $urandom_range(1, 10), -1);
      end

      run_cmd(2'd1, 8'h77, 1'b0, 8'h10, 8'h20, 8'hC0, 0, 2, 5);
      run_cmd(2'd1, 8'h78, 1'b1, 8'h30, 8'h40, 8'hD0, 0, 3, -1);
      run_cmd(2'd2, 8'h79, 1'b0, 8'h50, 8'h60, 8'hE0, 0, 3, -1);

      repeat (3) @(posedge clk);
      #1;
      chk("reads_left", 128'(exp_reads.size()), 128'(0));
      chk("writes_left", 128'(exp_writes.size()), 128'(0));
      chk("resp_left", 128'(exp_resp.size()), 128'(0));
      for (int i = 0; i < 256; i++) chk($sformatf("mem_final_%0d", i), 128'(mem[i]), 128'(ref_mem[i]));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/accel_dispatch_controller.md
ACCEL_DISPATCH_CONTROLLER -- requirements
Module: accel_dispatch_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles to wait for accelerator done/error.
REQ-002 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_sel  in  2  accelerator (0 crypto, 1 DSP, 2 AI)
- cmd_op  in  8  operation code
- cmd_fuse  in  1  chain: use previous result as data, skip writeback
- cmd_src  in  ADDR_W  data base address
- cmd_prm  in  ADDR_W  parameter base address
- cmd_dst  in  ADDR_W  result base address
- mem_req  out  1  memory access strobe
- mem_we  out  1  write when 1
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid exactly one cycle after read strobe
- acc_sel  out  2  to accelerator interface
- acc_op  out  8  to accelerator interface
- acc_enable  out  1  accelerator enable
- acc_fusion  out  1  fusion flag to accelerator interface
- acc_data  out  128  data bytes, byte k at [8k+7:8k]
- acc_param  out  128  parameter bytes, same packing
- acc_result  in  128  accelerator output, same packing
- acc_done  in  1  accelerator complete
- acc_error  in  1  accelerator error
- resp_valid  out  1  response pending
- resp_ready  in  1  response consumed
- resp_status  out  2  00 ok, 01 acc error, 10 timeout, 11 illegal sel

Function
REQ-004 SHALL implement states IDLE, LOAD, ISSUE, WAIT, STORE, RESP.
REQ-005 SHALL assert cmd_ready only in IDLE; accept latches sel/op/fuse/src/prm/dst.
REQ-006 SHALL, on accept with cmd_sel==3, go directly to RESP with status 11, no memory or accelerator activity.
REQ-007 SHALL, in LOAD, issue reads: 16 data bytes src..src+15 (skipped when cmd_fuse and result buffer valid), then 16 param bytes prm..prm+15, one per cycle, consecutive.
REQ-008 SHALL capture mem_rdata into byte slot one cycle after its address; leave LOAD the cycle after last capture.
REQ-009 SHALL compute addresses modulo 2^ADDR_W (wrap, e.g. 0xF8+15 -> 0x07).
REQ-010 SHALL, when fused, drive acc_data from the result buffer of the prior command.
REQ-011 SHALL assert acc_enable from ISSUE through WAIT, deasserting the cycle after done/error/timeout is sampled.
REQ-012 SHALL hold acc_sel, acc_op, acc_fusion, acc_data, acc_param stable while acc_enable is high.
REQ-013 SHALL, in WAIT, count cycles; done -> capture acc_result into result buffer, status 00; error (priority over done if simultaneous) -> status 01; count reaching TIMEOUT -> status 10.
REQ-014 SHALL go STORE only on status 00 and cmd_fuse==0: write 16 result bytes to dst..dst+15, one per cycle, then RESP.
REQ-015 SHALL, on status 00 and cmd_fuse==1, skip STORE and mark result buffer valid.
REQ-016 SHALL clear result buffer valid on any non-00 status.
REQ-017 SHALL hold resp_valid/resp_status in RESP until resp_ready, then return to IDLE the next cycle.
REQ-018 SHALL keep mem_req low outside LOAD/STORE; mem_we high only in STORE.

Reset
REQ-019 SHALL, on rst (asynchronous, any state), enter IDLE; all outputs 0 except cmd_ready=1 after release; buffers and result-valid cleared; abort in-flight operation without further memory writes.

Structure
REQ-020 SHALL place state encoding, status codes and selector constants in shared package accel_pkg.
REQ-021 SHALL be a single module with no sub-modules; timeout counter width clog2(TIMEOUT+1).

Verification
REQ-022 Non-fused DSP: sel=1, src=0x10, prm=0x40, dst=0x80, done 3 cycles after enable -> 32 reads, 16 writes of acc_result to 0x80..0x8F, status 00.
REQ-023 Fused chain: second cmd fuse=1 -> only 16 param reads, acc_data equals first result, no writes, status 00.
REQ-024 Error+done same cycle -> status 01, no writes, result-valid cleared.
REQ-025 No done for TIMEOUT=8 cycles -> acc_enable drops, status 10.
REQ-026 cmd_sel=3 -> resp_valid next cycle, status 11, mem_req never high.
REQ-027 src=0xF8 wrap check; rst asserted during STORE -> writes stop immediately, IDLE, cmd_ready=1 after release.
